// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART serializer among N_PORTS byte requesters: per-packet round-robin grant, baud tick, held byte.
// Define UART_TX_SCHED_FIXED_PRIO_EN to make arbitration always pick the lowest-index requester.
module uart_tx_scheduler #(
    parameter int N_PORTS  = 4,
    parameter int BAUD_DIV = 434,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_PORTS-1:0]   iREQ,
    input  logic [8*N_PORTS-1:0] iDATA,
    input  logic [N_PORTS-1:0]   iLAST,
    output logic [N_PORTS-1:0]   oACK,
    output logic [N_PORTS-1:0]   oGRANT,
    output logic                 oTX_BAUD_clk,
    output logic [7:0]           oTX_FIFO_DATA,
    output logic                 oFINISH,
    output logic                 oBUSY
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, ARB, LOAD, SEND} state_t;

    state_t             state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               last_q, last_d;
    logic [7:0]         data_q, data_d;
    logic               finish_q, finish_d;
    logic               tick_q, tick_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [3:0]         nbit_q, nbit_d;

    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               pick_vld;
    logic               wrap;

    always_comb begin
        pick     = '0;
        cand     = '0;
        pick_vld = 1'b0;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (iREQ[i]) begin
                pick     = IDX_W'(i);
                pick_vld = 1'b1;
            end
        end
`else
        // Scan from the far end so the port nearest rr_q+1 overrides the rest.
        for (int i = N_PORTS; i >= 1; i--) begin
            cand = IDX_W'((int'(rr_q) + i) % N_PORTS);
            if (iREQ[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
`endif
    end

    assign wrap = (div_q == DIV_MAX);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        win_d    = win_q;
        rr_d     = rr_q;
        last_d   = last_q;
        data_d   = data_q;
        finish_d = finish_q;
        tick_d   = 1'b0;
        div_d    = '0;
        nbit_d   = nbit_q;
        case (state_q)
            IDLE: begin
                finish_d = 1'b1;
                if (|iREQ) state_d = ARB;
            end
            ARB: begin
                if (pick_vld) begin
                    grant_d = N_PORTS'(1) << pick;
                    win_d   = pick;
                    rr_d    = pick;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                data_d   = iDATA[{win_q, 3'b000} +: 8];
                last_d   = iLAST[win_q];
                nbit_d   = '0;
                finish_d = 1'b0;
                state_d  = SEND;
            end
            SEND: begin
                div_d = wrap ? '0 : div_q + 1'b1;
                if (wrap) begin
                    tick_d = 1'b1;
                    nbit_d = nbit_q + 1'b1;
                    // This wrap emits the stop-bit tick; the next byte's LOAD overlaps it.
                    if (nbit_q == 4'd9) begin
                        nbit_d = '0;
                        if (!last_q && iREQ[win_q]) begin
                            state_d = LOAD;
                        end else begin
                            grant_d  = '0;
                            finish_d = 1'b1;
                            state_d  = (last_q && (|iREQ)) ? ARB : IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            win_q    <= '0;
            rr_q     <= IDX_W'(N_PORTS - 1);
            last_q   <= 1'b0;
            data_q   <= '0;
            finish_q <= 1'b1;
            tick_q   <= 1'b0;
            div_q    <= '0;
            nbit_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            win_q    <= win_d;
            rr_q     <= rr_d;
            last_q   <= last_d;
            data_q   <= data_d;
            finish_q <= finish_d;
            tick_q   <= tick_d;
            div_q    <= div_d;
            nbit_q   <= nbit_d;
        end
    end

    assign oACK          = (state_q == LOAD) ? grant_q : '0;
    assign oGRANT        = grant_q;
    assign oTX_BAUD_clk  = tick_q;
    assign oTX_FIFO_DATA = data_q;
    assign oFINISH       = finish_q;
    assign oBUSY         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: per-port byte queues feed the DUT, a packet-level model predicts grant order and timing.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
    localparam int N = 4;
    localparam int B = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     iREQ;
    logic [8*N-1:0]   iDATA;
    logic [N-1:0]     iLAST;
    logic [N-1:0]     oACK, oGRANT;
    logic             oTX_BAUD_clk;
    logic [7:0]       oTX_FIFO_DATA;
    logic             oFINISH, oBUSY;

    uart_tx_scheduler #(.N_PORTS(N), .BAUD_DIV(B), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .iREQ(iREQ), .iDATA(iDATA), .iLAST(iLAST),
        .oACK(oACK), .oGRANT(oGRANT), .oTX_BAUD_clk(oTX_BAUD_clk),
        .oTX_FIFO_DATA(oTX_FIFO_DATA), .oFINISH(oFINISH), .oBUSY(oBUSY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Driver queues (what the port FIFOs hold) and model copies of the same traffic.
    logic [7:0] qd [N][$];
    bit         ql [N][$];
    logic [7:0] md [N][$];
    bit         ml [N][$];

    int         ack_port [$];
    logic [7:0] ack_byte [$];
    int         ack_cyc  [$];
    int         tick_cyc [$];
    int         fin_hi = 0;
    int         ticks_since_ack = 0;
    int         cur_port = 0;
    logic [7:0] cur_byte = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int p);
        return N'(1) << p;
    endfunction

    function automatic bit queues_empty();
        for (int k = 0; k < N; k++) if (qd[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            iREQ[k]          = (qd[k].size() != 0);
            iDATA[8*k +: 8]  = (qd[k].size() != 0) ? qd[k][0] : 8'h00;
            iLAST[k]         = (qd[k].size() != 0) ? ql[k][0] : 1'b0;
        end
    endtask

    task automatic push_byte(input int p, input logic [7:0] d, input bit lst);
        qd[p].push_back(d); ql[p].push_back(lst);
        md[p].push_back(d); ml[p].push_back(lst);
    endtask

    task automatic clear_logs();
        ack_port.delete(); ack_byte.delete(); ack_cyc.delete(); tick_cyc.delete();
        fin_hi = 0;
        ticks_since_ack = 0;
    endtask

    // Monitor at the falling edge, then pop whatever was acked and re-present queue heads.
    initial begin
        logic [N-1:0] a;
        forever begin
            @(negedge clk);
            a = oACK;
            if (!reset) begin
                if (oTX_BAUD_clk) begin
                    tick_cyc.push_back(cyc);
                    ticks_since_ack++;
                    chk("tick_data", oTX_FIFO_DATA, cur_byte);
                    if (ticks_since_ack < 10) chk("tick_grant", oGRANT, onehot(cur_port));
                end
                if (a != '0) begin
                    for (int k = 0; k < N; k++) if (a[k]) begin
                        cur_port = k;
                        cur_byte = iDATA[8*k +: 8];
                    end
                    ack_port.push_back(cur_port);
                    ack_byte.push_back(cur_byte);
                    ack_cyc.push_back(cyc);
                    ticks_since_ack = 0;
                end else if (ack_port.size() > 0 && oFINISH && oBUSY) begin
                    fin_hi++;
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) if (a[k] && qd[k].size() != 0) begin
                void'(qd[k].pop_front());
                void'(ql[k].pop_front());
            end
            drive();
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            qd[k].delete(); ql[k].delete(); md[k].delete(); ml[k].delete();
        end
        drive();
        repeat (3) @(negedge clk);
        chk("rst_ack",    oACK, 0);
        chk("rst_grant",  oGRANT, 0);
        chk("rst_tick",   oTX_BAUD_clk, 0);
        chk("rst_data",   oTX_FIFO_DATA, 0);
        chk("rst_finish", oFINISH, 1);
        chk("rst_busy",   oBUSY, 0);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        bit done = 1'b0;
        while (!done && t < 20000) begin
            @(negedge clk);
            #1;
            t++;
            done = !oBUSY && queues_empty();
        end
        chk({nm, "_done"}, done, 1);
        repeat (3) @(negedge clk);
    endtask

    // Packet-level model: whole packets are granted, next owner chosen by rotating (or fixed) priority.
    // Gap between acks: same packet 10B+1, new packet via ARB 10B+2, after an abort via IDLE 10B+3.
    task automatic check_model(input string nm);
        int         ep [$];
        logic [7:0] eb [$];
        int         ekind [$];
        int         rr = N - 1;
        int         p;
        bit         lst;
        forever begin
            p = -1;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
            for (int i = 0; i < N && p < 0; i++) if (md[i].size() != 0) p = i;
`else
            for (int i = 1; i <= N && p < 0; i++) if (md[(rr + i) % N].size() != 0) p = (rr + i) % N;
`endif
            if (p < 0) break;
            rr = p;
            do begin
                eb.push_back(md[p].pop_front());
                lst = ml[p].pop_front();
                ep.push_back(p);
                ekind.push_back(lst ? 1 : (md[p].size() == 0 ? 2 : 0));
            end while (!lst && md[p].size() != 0);
        end
        chk({nm, "_nack"}, ack_port.size(), ep.size());
        chk({nm, "_nticks"}, tick_cyc.size(), 10 * ep.size());
        for (int i = 0; i < ep.size() && i < ack_port.size(); i++) begin
            chk({nm, "_port"}, ack_port[i], ep[i]);
            chk({nm, "_byte"}, ack_byte[i], eb[i]);
            if (i > 0) chk({nm, "_gap"}, ack_cyc[i] - ack_cyc[i-1], 10 * B + 1 + ekind[i-1]);
        end
    endtask

    typedef struct {
        logic [N-1:0] mask;
        logic [7:0]   base;
        int           exp_port;
        logic [7:0]   exp_byte;
    } vec_t;

    initial begin
        vec_t tbl [5];
        int   bad, g8, g9, cnt, t;

        #950_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [5];
        int   bad, g8, g9, cnt, t;
        tbl[0] = '{4'b0001, 8'hA0, 0, 8'hA0};
        tbl[1] = '{4'b0100, 8'h30, 2, 8'h32};
        tbl[2] = '{4'b1010, 8'h50, 1, 8'h51};
        tbl[3] = '{4'b1100, 8'h70, 2, 8'h72};
        tbl[4] = '{4'b0000, 8'h00, -1, 8'h00};

        reset = 1'b1;
        iREQ = '0; iDATA = '0; iLAST = '0;
        do_reset();

        // First grant after reset for a set of simultaneous single-byte requests.
        foreach (tbl[r]) begin
            do_reset();
            for (int k = 0; k < N; k++) if (tbl[r].mask[k]) push_byte(k, 8'(tbl[r].base + k), 1'b1);
            t = 0;
            while (ack_port.size() == 0 && t < 40) begin
                @(negedge clk); #1; t++;
            end
            chk("tbl_nack", ack_port.size(), (tbl[r].exp_port < 0) ? 0 : 1);
            if (ack_port.size() > 0) begin
                chk("tbl_port", ack_port[0], tbl[r].exp_port);
                chk("tbl_byte", ack_byte[0], tbl[r].exp_byte);
            end else begin
                chk("tbl_idle_busy", oBUSY, 0);
            end
        end

        // Single byte 0xA5: ten evenly spaced ticks, then line released.
        do_reset();
        push_byte(0, 8'hA5, 1'b1);
        wait_done("one");
        check_model("one");
        if (ack_cyc.size() > 0 && tick_cyc.size() > 0) chk("one_first_tick", tick_cyc[0] - ack_cyc[0], B + 1);
        bad = 0;
        for (int i = 1; i < tick_cyc.size(); i++) if (tick_cyc[i] - tick_cyc[i-1] != B) bad++;
        chk("one_tick_spacing_bad", bad, 0);
        chk("one_finish", oFINISH, 1);
        chk("one_grant", oGRANT, 0);

        // Ports 0 and 2 compete with single-byte packets.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            push_byte(0, 8'(8'h00 + j), 1'b1);
            push_byte(2, 8'(8'h20 + j), 1'b1);
        end
        wait_done("alt");
        check_model("alt");

        // 3-byte packet on port 1 holds off port 3 for 30 ticks.
        do_reset();
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h33, 1'b1);
        push_byte(3, 8'hD3, 1'b1);
        wait_done("hold");
        check_model("hold");
        if (ack_cyc.size() >= 4) begin
            cnt = 0;
            foreach (tick_cyc[i]) if (tick_cyc[i] > ack_cyc[0] && tick_cyc[i] < ack_cyc[3]) cnt++;
            chk("hold_ticks", cnt, 30);
        end

        // Requester runs dry mid-packet: grant released after the current byte.
        do_reset();
        push_byte(2, 8'h9C, 1'b0);
        wait_done("abort");
        check_model("abort");
        chk("abort_grant", oGRANT, 0);
        chk("abort_finish", oFINISH, 1);

        // Reset while the fifth tick is on the line.
        do_reset();
        push_byte(2, 8'h5A, 1'b1);
        t = 0;
        while (tick_cyc.size() < 5 && t < 400) begin
            @(negedge clk); #1; t++;
        end
        chk("mid_tick5_seen", tick_cyc.size(), 5);
        reset = 1'b1;
        #1;
        chk("mid_finish", oFINISH, 1);
        chk("mid_grant", oGRANT, 0);
        chk("mid_tick", oTX_BAUD_clk, 0);
        chk("mid_busy", oBUSY, 0);
        do_reset();
        push_byte(0, 8'hC0, 1'b1);
        push_byte(3, 8'hC3, 1'b1);
        wait_done("restart");
        check_model("restart");

        // Ten back-to-back bytes in one packet.
        do_reset();
        for (int j = 0; j < 10; j++) push_byte(0, 8'($urandom), j == 9);
        wait_done("b2b");
        check_model("b2b");
        chk("b2b_finish_gaps", fin_hi, 0);
        g8 = 0; g9 = 0; bad = 0;
        for (int i = 1; i < tick_cyc.size(); i++) begin
            if (tick_cyc[i] - tick_cyc[i-1] == B) g8++;
            else if (tick_cyc[i] - tick_cyc[i-1] == B + 1) g9++;
            else bad++;
        end
        chk("b2b_gap_B", g8, 90);
        chk("b2b_gap_B1", g9, 9);
        chk("b2b_gap_other", bad, 0);

        // Random packet mixes across all ports.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int pk = 0; pk < 8; pk++) begin
                int p   = $urandom_range(0, N - 1);
                int len = $urandom_range(1, 3);
                for (int j = 0; j < len; j++) push_byte(p, 8'($urandom), j == len - 1);
            end
            wait_done("rnd");
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Controller that shares one 8N1 UART serializer between N_PORTS byte requesters. Arbitrates round-robin per packet and holds the grant until the requester's last byte. Generates the baud tick that steps the serializer, presents a stable byte to it, and holds it idle (line high) between packets via the finish line. Sits between per-port TX FIFOs and the serializer.

Parameters:
N_PORTS, 4, number of requesters (2..8)
BAUD_DIV, 434, clk cycles per bit period (50 MHz / 115200); minimum 4
CNT_W, 16, width of the baud divider counter; must hold BAUD_DIV-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
iREQ  input  N_PORTS  per-port byte available (level)
iDATA  input  8*N_PORTS  per-port byte; port k at [8k+7:8k]
iLAST  input  N_PORTS  per-port: current byte ends the packet
oACK  output  N_PORTS  one-clk pulse: port byte consumed (FIFO pop)
oGRANT  output  N_PORTS  one-hot owner of the serializer, 0 when free
oTX_BAUD_clk  output  1  registered one-clk-wide tick to serializer
oTX_FIFO_DATA  output  8  byte held stable for serializer
oFINISH  output  1  high = serializer forced idle / line high
oBUSY  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, oACK=0, oGRANT=0, oTX_BAUD_clk=0, oTX_FIFO_DATA=0, oFINISH=1, oBUSY=0, divider=0, tick count=0, rr pointer=N_PORTS-1 (port 0 wins first).
- IDLE: oFINISH=1. Any iREQ bit high -> ARB next cycle.
- ARB (1 clk): winner = first requesting port searching upward from rr pointer+1, modulo N_PORTS. Register oGRANT one-hot and rr pointer=winner. -> LOAD.
- LOAD (1 clk): oTX_FIFO_DATA <= iDATA[winner]; latch iLAST[winner]; oACK[winner] pulses this cycle only. Clear divider and tick count. oFINISH <= 0. -> SEND.
- SEND: divider counts 0..BAUD_DIV-1 and wraps. oTX_BAUD_clk=1 for exactly the clk after divider==BAUD_DIV-1. Tick count increments per tick. After the 10th tick (start, 8 data, stop driven by the serializer):
  - latched last=0 and iREQ[winner]=1 -> LOAD, same grant (back-to-back byte).
  - latched last=0 and iREQ[winner]=0 -> abort: oGRANT=0, -> IDLE.
  - latched last=1 -> oGRANT=0; -> ARB if any iREQ high, else IDLE.
- Byte timing: first tick is BAUD_DIV clks after LOAD. Each character is 10*BAUD_DIV clks. Stop bit lasts at least BAUD_DIV clks before the next start.
- oTX_FIFO_DATA and oGRANT do not change during SEND. iDATA changes after oACK have no effect.
- Requests from non-granted ports are ignored until the grant releases. No preemption.
- iREQ deasserting during SEND does not disturb the current byte. It is only sampled at the end-of-byte decision.
- oBUSY=1 in ARB, LOAD, SEND.
- Divider free-runs only in SEND. Held at 0 elsewhere; no tick outside SEND.
- A single requester re-requesting after its last byte is re-granted via ARB, with 2 clks of idle line.

Optional Feature:
UART_TX_SCHED_FIXED_PRIO_EN
- Defined: ARB always picks the lowest-index requesting port. rr pointer is unused.
- Undefined: round-robin as above.
- Packet grant-hold, abort and timing are identical in both builds.

Test Plan:
- BAUD_DIV=8. Port 0 sends one byte 0xA5 with last=1 -> oACK[0] one pulse, oTX_FIFO_DATA=0xA5 held, exactly 10 ticks spaced 8 clks, oFINISH back to 1, oGRANT=0.
- Ports 0 and 2 both request single-byte packets continuously -> grants alternate 0,2,0,2. With FIXED_PRIO_EN -> grant stays 0.
- Port 1 sends 3-byte packet 0x11,0x22,0x33 (last on 0x33) while port 3 requests -> port 1 holds grant for 30 ticks, then port 3 is granted.
- Port 2 drops iREQ after byte 1 of a 4-byte packet (last=0) -> grant releases after the 10th tick, state IDLE, oFINISH=1, only 1 oACK.
- Assert reset mid-SEND at tick 5 -> same-cycle oFINISH=1, oGRANT=0, oTX_BAUD_clk=0. After release, a fresh request restarts from port 0.
- Request held for 10 back-to-back bytes -> oACK count=10, no oFINISH pulse between bytes, tick spacing always BAUD_DIV except the +1 clk at each LOAD.
